// File: rtl/exec_pkg.sv
// Shared encodings for the execute controller: opcodes, condition/flag codes,
// controller states and the opcode-to-ALU-function mapping.
package exec_pkg;

    localparam int DEF_WIDTH     = 11;
    localparam int DEF_SAT_LIMIT = 999;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_NOT = 4'd3;
    localparam logic [3:0] OP_TLT = 4'd4;
    localparam logic [3:0] OP_TGT = 4'd5;
    localparam logic [3:0] OP_TEQ = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_SLP = 4'd8;
    localparam logic [3:0] OP_NOP = 4'd9;

    localparam logic [1:0] COND_ALWAYS  = 2'b00;
    localparam logic [1:0] COND_PLUS    = 2'b01;
    localparam logic [1:0] COND_MINUS   = 2'b10;
    localparam logic [1:0] COND_ALWAYS2 = 2'b11;

    localparam logic [1:0] FLAG_NONE  = 2'b00;
    localparam logic [1:0] FLAG_PLUS  = 2'b01;
    localparam logic [1:0] FLAG_MINUS = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SLEEP = 2'd2
    } state_e;

    // ALU ops pass straight through; everything else parks the ALU on ADD.
    function automatic logic [3:0] op_to_funct(input logic [3:0] op);
        return (op <= OP_TGT) ? op : OP_ADD;
    endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational saturation of a result to [-SAT_LIMIT, SAT_LIMIT]; on overflow
// the caller-supplied direction picks the rail.
module sat_clamp #(
    parameter int WIDTH     = 11,
    parameter int SAT_LIMIT = 999
) (
    input  logic [WIDTH-1:0] value,
    input  logic             ovf,
    input  logic             dir_neg,
    output logic [WIDTH-1:0] result,
    output logic             clamped
);

    localparam logic signed [WIDTH-1:0] POS_LIM = WIDTH'(SAT_LIMIT);
    localparam logic signed [WIDTH-1:0] NEG_LIM = WIDTH'(-SAT_LIMIT);

    always_comb begin
        result  = value;
        clamped = 1'b0;
        if (ovf) begin
            result  = dir_neg ? NEG_LIM : POS_LIM;
            clamped = 1'b1;
        end else if ($signed(value) > POS_LIM) begin
            result  = POS_LIM;
            clamped = 1'b1;
        end else if ($signed(value) < NEG_LIM) begin
            result  = NEG_LIM;
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/exec_ctrl.sv
// Execute controller: handshakes decoded instructions, drives the ALU, owns the
// accumulator, +/- condition flag and SLP timer. Saturation: EXEC_SATURATE_EN.
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SAT_LIMIT = DEF_SAT_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_op,
    input  logic [1:0]       instr_cond,
    input  logic [WIDTH-1:0] instr_operand,
    input  logic             sleep_tick,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [3:0]       alu_funct,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    output logic [WIDTH-1:0] acc,
    output logic [1:0]       cond_flag,
    output logic             busy,
    output logic             ovf_sticky
);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [1:0]       cond_q, cond_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [3:0]       funct_q, funct_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [1:0]       flag_q, flag_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             live_q, live_d;

    logic             exec_en;
    logic             is_arith;
    logic [WIDTH-1:0] res_raw;
    logic [WIDTH-1:0] res_val;
    logic             res_ovf;
    logic             clamp_hit;

    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                      (op_q == OP_MUL) || (op_q == OP_NOT);
    assign exec_en  = (cond_q == COND_ALWAYS) || (cond_q == COND_ALWAYS2) ||
                      (cond_q == flag_q);
    assign res_raw  = (op_q == OP_MOV) ? opnd_q : alu_out;
    assign res_ovf  = is_arith & alu_overflow;

`ifdef EXEC_SATURATE_EN
    logic dir_neg;

    // MUL overflows toward the sign of the product, ADD/SUB toward the accumulator.
    assign dir_neg = (op_q == OP_MUL) ? (acc_q[WIDTH-1] ^ opnd_q[WIDTH-1]) : acc_q[WIDTH-1];

    sat_clamp #(
        .WIDTH     (WIDTH),
        .SAT_LIMIT (SAT_LIMIT)
    ) u_sat_clamp (
        .value   (res_raw),
        .ovf     (res_ovf),
        .dir_neg (dir_neg),
        .result  (res_val),
        .clamped (clamp_hit)
    );
`else
    assign res_val   = res_raw;
    assign clamp_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cond_d  = cond_q;
        opnd_d  = opnd_q;
        funct_d = funct_q;
        acc_d   = acc_q;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        live_d  = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid && live_q) begin
                    op_d    = instr_op;
                    cond_d  = instr_cond;
                    opnd_d  = instr_operand;
                    funct_d = op_to_funct(instr_op);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                if (exec_en) begin
                    case (op_q)
                        OP_ADD, OP_SUB, OP_MUL, OP_NOT, OP_MOV: begin
                            acc_d = res_val;
                            ovf_d = ovf_q | res_ovf | clamp_hit;
                        end
                        OP_TLT, OP_TGT: flag_d = (alu_out != '0) ? FLAG_PLUS : FLAG_MINUS;
                        OP_TEQ:         flag_d = (acc_q == opnd_q) ? FLAG_PLUS : FLAG_MINUS;
                        OP_SLP: begin
                            if (!opnd_q[WIDTH-1] && (opnd_q != '0)) begin
                                cnt_d   = opnd_q;
                                state_d = ST_SLEEP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_SLEEP: begin
                // Leave on the edge that samples the final tick.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else if (sleep_tick) begin
                    cnt_d = cnt_q - WIDTH'(1);
                    if (cnt_q == WIDTH'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            cond_q  <= COND_ALWAYS;
            opnd_q  <= '0;
            funct_q <= '0;
            acc_q   <= '0;
            flag_q  <= FLAG_NONE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cond_q  <= cond_d;
            opnd_q  <= opnd_d;
            funct_q <= funct_d;
            acc_q   <= acc_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            live_q  <= live_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE) && live_q;
    assign busy        = (state_q != ST_IDLE);
    assign alu_in0     = acc_q;
    assign alu_in1     = opnd_q;
    assign alu_funct   = funct_q;
    assign acc         = acc_q;
    assign cond_flag   = flag_q;
    assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with a behavioural 11-bit ALU attached.
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [1:0]  instr_cond;
    logic [10:0] instr_operand;
    logic        sleep_tick;
    logic [10:0] alu_in0;
    logic [10:0] alu_in1;
    logic [3:0]  alu_funct;
    logic [10:0] alu_out;
    logic        alu_overflow;
    logic [10:0] acc;
    logic [1:0]  cond_flag;
    logic        busy;
    logic        ovf_sticky;

    int n_checks = 0;
    int n_fail   = 0;
    int alu_r;

    exec_ctrl #(.WIDTH(11), .SAT_LIMIT(999)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_cond    (instr_cond),
        .instr_operand (instr_operand),
        .sleep_tick    (sleep_tick),
        .alu_in0       (alu_in0),
        .alu_in1       (alu_in1),
        .alu_funct     (alu_funct),
        .alu_out       (alu_out),
        .alu_overflow  (alu_overflow),
        .acc           (acc),
        .cond_flag     (cond_flag),
        .busy          (busy),
        .ovf_sticky    (ovf_sticky)
    );

    always #5 clk = ~clk;

    // Reference ALU: signed 11-bit arithmetic with overflow on ADD/SUB/MUL.
    always_comb begin
        alu_r = 0;
        case (alu_funct)
            4'd0: alu_r = int'($signed(alu_in0)) + int'($signed(alu_in1));
            4'd1: alu_r = int'($signed(alu_in0)) - int'($signed(alu_in1));
            4'd2: alu_r = int'($signed(alu_in0)) * int'($signed(alu_in1));
            4'd3: alu_r = int'($signed(~alu_in0));
            4'd4: alu_r = ($signed(alu_in0) < $signed(alu_in1)) ? 1 : 0;
            4'd5: alu_r = ($signed(alu_in0) > $signed(alu_in1)) ? 1 : 0;
            default: alu_r = 0;
        endcase
        alu_out      = alu_r[10:0];
        alu_overflow = (alu_funct <= 4'd2) && ((alu_r > 1023) || (alu_r < -1024));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the handshake edge, i.e. inside the EXEC cycle.
    task automatic send(input logic [3:0] op, input logic [1:0] cond, input int opnd);
        int n = 0;
        instr_valid   = 1'b1;
        instr_op      = op;
        instr_cond    = cond;
        instr_operand = 11'(opnd);
        while (!instr_ready && n < 40) begin
            step();
            n++;
        end
        n_checks++;
        if (!instr_ready) begin
            n_fail++;
            $display("FAIL handshake_timeout: ready=%0b after %0d cycles, want 1", instr_ready, n);
        end
        step();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({acc, cond_flag, instr_ready, busy, ovf_sticky} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: acc=%0d flag=%b rdy=%b busy=%b ovf=%b, want all 0",
                     acc, cond_flag, instr_ready, busy, ovf_sticky);
        end
        n_checks++;
        if (alu_in1 !== 11'd0 || alu_funct !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_alu: in1=%0d funct=%0d, want 0 0", alu_in1, alu_funct);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", instr_ready);
        end
    endtask

    task automatic test_skip_none();
        send(4'd0, 2'b01, 7);
        step();
        n_checks++;
        if (acc !== 11'd0) begin
            n_fail++;
            $display("FAIL skip_plus_none: acc=%0d want 0", $signed(acc));
        end
        send(4'd7, 2'b10, 4);
        step();
        n_checks++;
        if (acc !== 11'd0) begin
            n_fail++;
            $display("FAIL skip_minus_none: acc=%0d want 0", $signed(acc));
        end
        send(4'd7, 2'b11, 4);
        step();
        n_checks++;
        if (acc !== 11'd4) begin
            n_fail++;
            $display("FAIL cond11_always: acc=%0d want 4", $signed(acc));
        end
        send(4'd2, 2'b00, 3);
        n_checks++;
        if (alu_funct !== 4'd2) begin
            n_fail++;
            $display("FAIL mul_funct: got %0d want 2", alu_funct);
        end
        step();
        n_checks++;
        if (acc !== 11'd12) begin
            n_fail++;
            $display("FAIL mul_acc: acc=%0d want 12", $signed(acc));
        end
        send(4'd3, 2'b00, 0);
        n_checks++;
        if (alu_funct !== 4'd3) begin
            n_fail++;
            $display("FAIL not_funct: got %0d want 3", alu_funct);
        end
        step();
        n_checks++;
        if ($signed(acc) !== -11'sd13 || cond_flag !== 2'b00) begin
            n_fail++;
            $display("FAIL not_acc: acc=%0d flag=%b want -13 00", $signed(acc), cond_flag);
        end
    endtask

    task automatic test_mov_add();
        send(4'd7, 2'b00, 5);
        n_checks++;
        if (instr_ready !== 1'b0 || busy !== 1'b1 || acc !== 11'(-13)) begin
            n_fail++;
            $display("FAIL mov_exec: rdy=%b busy=%b acc=%0d want 0 1 -13", instr_ready, busy, $signed(acc));
        end
        n_checks++;
        if (alu_in1 !== 11'd5 || alu_funct !== 4'd0) begin
            n_fail++;
            $display("FAIL mov_alu_drive: in1=%0d funct=%0d want 5 0", alu_in1, alu_funct);
        end
        step();
        n_checks++;
        if (acc !== 11'd5 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mov_acc: acc=%0d rdy=%b want 5 1", $signed(acc), instr_ready);
        end
        send(4'd0, 2'b00, 7);
        n_checks++;
        if (instr_ready !== 1'b0 || acc !== 11'd5) begin
            n_fail++;
            $display("FAIL add_exec: rdy=%b acc=%0d want 0 5", instr_ready, $signed(acc));
        end
        step();
        n_checks++;
        if (acc !== 11'd12) begin
            n_fail++;
            $display("FAIL add_acc: acc=%0d want 12", $signed(acc));
        end
    endtask

    task automatic test_cond();
        send(4'd5, 2'b00, 10);
        n_checks++;
        if (alu_funct !== 4'd5) begin
            n_fail++;
            $display("FAIL tgt_funct: got %0d want 5", alu_funct);
        end
        step();
        n_checks++;
        if (cond_flag !== 2'b01 || acc !== 11'd12) begin
            n_fail++;
            $display("FAIL tgt_flag: flag=%b acc=%0d want 01 12", cond_flag, $signed(acc));
        end
        send(4'd0, 2'b10, 100);
        step();
        n_checks++;
        if (acc !== 11'd12) begin
            n_fail++;
            $display("FAIL minus_add_skip: acc=%0d want 12", $signed(acc));
        end
        send(4'd1, 2'b01, 2);
        step();
        n_checks++;
        if (acc !== 11'd10) begin
            n_fail++;
            $display("FAIL plus_sub: acc=%0d want 10", $signed(acc));
        end
        send(4'd6, 2'b00, 10);
        n_checks++;
        if (alu_funct !== 4'd0) begin
            n_fail++;
            $display("FAIL teq_funct: got %0d want 0", alu_funct);
        end
        step();
        n_checks++;
        if (cond_flag !== 2'b01) begin
            n_fail++;
            $display("FAIL teq_eq: flag=%b want 01", cond_flag);
        end
        send(4'd6, 2'b00, 3);
        step();
        n_checks++;
        if (cond_flag !== 2'b10 || acc !== 11'd10) begin
            n_fail++;
            $display("FAIL teq_ne: flag=%b acc=%0d want 10 10", cond_flag, $signed(acc));
        end
        send(4'd4, 2'b00, 20);
        step();
        n_checks++;
        if (cond_flag !== 2'b01) begin
            n_fail++;
            $display("FAIL tlt_flag: flag=%b want 01", cond_flag);
        end
        send(4'd1, 2'b10, 1);
        step();
        n_checks++;
        if (acc !== 11'd10 || cond_flag !== 2'b01) begin
            n_fail++;
            $display("FAIL minus_sub_skip: acc=%0d flag=%b want 10 01", $signed(acc), cond_flag);
        end
    endtask

    task automatic test_overflow();
        logic [10:0] exp_acc;
`ifdef EXEC_SATURATE_EN
        exp_acc = 11'd999;
`else
        exp_acc = 11'(-948);
`endif
        send(4'd7, 2'b00, 900);
        step();
        n_checks++;
        if (acc !== 11'd900 || ovf_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL mov_900: acc=%0d ovf=%b want 900 0", $signed(acc), ovf_sticky);
        end
        send(4'd0, 2'b00, 200);
        step();
        n_checks++;
        if (acc !== exp_acc || ovf_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL add_overflow: acc=%0d ovf=%b want %0d 1", $signed(acc), ovf_sticky, $signed(exp_acc));
        end
        send(4'd7, 2'b00, 5);
        step();
        n_checks++;
        if (acc !== 11'd5 || ovf_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky_hold: acc=%0d ovf=%b want 5 1", $signed(acc), ovf_sticky);
        end
    endtask

    task automatic test_sleep();
        int ticks = 0;
        logic exp_busy;
        send(4'd8, 2'b00, 3);
        sleep_tick = 1'b1;
        step();
        sleep_tick = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL slp_enter: busy=%b rdy=%b want 1 0", busy, instr_ready);
        end
        for (int c = 1; c <= 14; c++) begin
            sleep_tick = (c % 4 == 0);
            step();
            if (sleep_tick) ticks++;
            sleep_tick = 1'b0;
            exp_busy = (ticks < 3);
            n_checks++;
            if (busy !== exp_busy || instr_ready !== !exp_busy) begin
                n_fail++;
                $display("FAIL slp_wait c=%0d: busy=%b rdy=%b want busy %b", c, busy, instr_ready, exp_busy);
            end
        end
        send(4'd8, 2'b00, -2);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL slp_neg_exec: busy=%b want 1", busy);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL slp_neg_idle: busy=%b rdy=%b want 0 1", busy, instr_ready);
        end
    endtask

    task automatic test_reset_mid_sleep();
        send(4'd7, 2'b00, 10);
        step();
        send(4'd8, 2'b00, 5);
        step();
        sleep_tick = 1'b1;
        step();
        sleep_tick = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || acc !== 11'd10) begin
            n_fail++;
            $display("FAIL sleep_before_reset: busy=%b acc=%0d want 1 10", busy, $signed(acc));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || acc !== 11'd0 || instr_ready !== 1'b0 || ovf_sticky !== 1'b0 || cond_flag !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b acc=%0d rdy=%b ovf=%b flag=%b want 0 0 0 0 00",
                     busy, $signed(acc), instr_ready, ovf_sticky, cond_flag);
        end
        sleep_tick = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        sleep_tick = 1'b0;
        step();
        n_checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || acc !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_release2: rdy=%b busy=%b acc=%0d want 1 0 0", instr_ready, busy, $signed(acc));
        end
        for (int c = 0; c < 4; c++) begin
            sleep_tick = 1'b1;
            step();
            sleep_tick = 1'b0;
            n_checks++;
            if (busy !== 1'b0 || alu_in1 !== 11'd0) begin
                n_fail++;
                $display("FAIL tick_after_reset c=%0d: busy=%b in1=%0d want 0 0", c, busy, alu_in1);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        instr_valid   = 1'b0;
        instr_op      = 4'd0;
        instr_cond    = 2'b00;
        instr_operand = 11'd0;
        sleep_tick    = 1'b0;
        #1;
        test_reset();
        test_skip_none();
        test_mov_add();
        test_cond();
        test_overflow();
        test_sleep();
        test_reset_mid_sleep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Execute controller for the 11-bit microcontroller core, sitting directly upstream and downstream of the combinational ALU. It accepts decoded instructions over a valid/ready handshake and drives the ALU operands and function code. It captures the ALU result into the accumulator and maintains the `+`/`-` condition state that gates conditional instructions. It also implements the multi-cycle `SLP` instruction against an external time-unit tick.

## Interface
Parameters:
- `WIDTH`, 11, datapath width (two's complement).
- `SAT_LIMIT`, 999, magnitude limit used when saturation is compiled in.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  controller can accept.
- `instr_op`  in  4  opcode.
- `instr_cond`  in  2  00 always, 01 `+` only, 10 `-` only, 11 treated as always.
- `instr_operand`  in  WIDTH  signed operand.
- `sleep_tick`  in  1  one-cycle pulse per sleep time unit.
- `alu_in0`  out  WIDTH  always equals `acc`.
- `alu_in1`  out  WIDTH  operand of the held instruction.
- `alu_funct`  out  4  ALU function code.
- `alu_out`  in  WIDTH  ALU result.
- `alu_overflow`  in  1  ALU overflow.
- `acc`  out  WIDTH  accumulator.
- `cond_flag`  out  2  00 none, 01 plus, 10 minus.
- `busy`  out  1  high in EXEC or SLEEP.
- `ovf_sticky`  out  1  set on any overflow or clamp; cleared only by reset.

## Operation
- Opcodes 0 ADD, 1 SUB, 2 MUL, 3 NOT, 4 TLT and 5 TGT pass through unchanged as `alu_funct`.
- Opcodes 6 TEQ, 7 MOV, 8 SLP and 9 NOP drive `alu_funct`=0. Opcodes 10-15 behave as NOP.
- States: IDLE → EXEC on handshake (`instr_valid & instr_ready`), which latches op, cond and operand.
- EXEC → IDLE, except an executed SLP with operand > 0 goes EXEC → SLEEP.
- SLEEP → IDLE when the counter reaches 0.
- `instr_ready` = (state == IDLE).
- Condition check happens in EXEC. The instruction executes if cond is always, or if cond matches `cond_flag`. With `cond_flag`=none, every conditional instruction is skipped.
- A skipped instruction still spends one EXEC cycle and changes no state.
- ADD, SUB, MUL and NOT: `acc` ← `alu_out`, after the optional clamp.
- MOV: `acc` ← operand, after the optional clamp.
- TLT and TGT: `cond_flag` ← plus if `alu_out` ≠ 0, else minus.
- TEQ: `cond_flag` ← plus if `acc` == operand, else minus. Computed locally, not through the ALU.
- Test instructions never modify `acc`. `cond_flag` persists until the next test instruction or reset.
- SLP: counter ← operand. Operand ≤ 0 means no sleep.
- In SLEEP, each `sleep_tick` decrements the counter. A tick in the EXEC cycle is ignored.
- `ovf_sticky` sets when an executed arithmetic op sees `alu_overflow`=1, or when a clamp occurs.

## Timing
- Reset values: `acc`=0, `cond_flag`=00, state IDLE, `instr_ready`=0 while `rst_n` is low and 1 from the first cycle after release, `busy`=0, `ovf_sticky`=0, counter=0, `alu_in1`=0, `alu_funct`=0.
- Handshake at edge N; EXEC during cycle N; `acc`/`cond_flag` update at edge N+1; `instr_ready` high again in the cycle after N+1.
- Peak throughput is one instruction per 2 cycles.
- SLP k (k>0): returns to IDLE on the edge at which the k-th tick is sampled in SLEEP.
- Reset assertion in any state takes effect immediately: the sleep is aborted and all registers take their reset values.
- `alu_in1` and `alu_funct` are registered and stable throughout EXEC.

## Configuration
- `EXEC_SATURATE_EN` defined:
  - Results are clamped to [-SAT_LIMIT, SAT_LIMIT].
  - On `alu_overflow`, the clamp direction is the sign of `alu_in0` for ADD/SUB, and `alu_in0[MSB]^alu_in1[MSB]` for MUL (0 → +limit).
  - MOV operands are clamped too.
  - A clamp sets `ovf_sticky`.
- Not defined: `acc` takes `alu_out` (or the operand) raw, wrapping at WIDTH bits. Only `alu_overflow` sets `ovf_sticky`.

## Structure
- Package `exec_pkg`: opcode constants, cond encodings, flag encodings, state enum, default WIDTH.
- Sub-module `sat_clamp`: combinational clamp taking value, overflow and direction, returning the clamped value and a clamped bit. Instantiated only under `EXEC_SATURATE_EN`.

## Test plan
- Reset: hold `rst_n` low mid-stream → `acc`=0, `cond_flag`=00, `instr_ready`=0. Release → `instr_ready`=1 next cycle.
- MOV 5, then ADD 7 → `acc`=5, then 12. Each update lands one edge after its handshake; `instr_ready` is low during EXEC.
- With `acc`=12: TGT 10 → flag plus. `-`ADD 100 → skipped, `acc` stays 12. `+`SUB 2 → `acc`=10. Next, with `acc`=10: TEQ 10 → flag plus.
- MOV 900, ADD 200:
  - With `EXEC_SATURATE_EN`: `acc`=999, `ovf_sticky`=1.
  - Without it: `acc`=-948, `ovf_sticky`=1 via `alu_overflow`.
- SLP 3 with ticks every 4 cycles → `busy` holds until the 3rd tick, then IDLE. SLP -2 → IDLE after one EXEC cycle.
- Assert `rst_n` mid-SLEEP with `acc`=10 → immediately IDLE, `acc`=0, `busy`=0, further ticks ignored.
